// File: rtl/rs232_fifo_uart.sv
// rs232_fifo_uart: UART peripheral with RX/TX FIFOs behind a 2-register (DATA/STATUS) bus slave.
// Latency: rdata/rvalid one cycle after a read strobe; a TX frame starts the cycle after the TX FIFO goes non-empty.
// Backpressure: none on the bus; full TX FIFO drops writes (TX_OVF), full RX FIFO drops bytes (OVERRUN).
// Build option: define RS232_PARITY_EN for an even parity bit on TX and parity checking on RX.

// rs232_fifo: generic synchronous FIFO, pointers one bit wider than the address to tell full from empty.
// Latency: pop_dat is the combinational head; a push is visible at the head the cycle after it lands.
// Backpressure: push while full is dropped unless a pop happens in the same cycle; pop while empty returns 0.
module rs232_fifo #(
    parameter int W  = 8,
    parameter int AW = 4
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] pop_dat,
    output logic         empty,
    output logic         full
);
    logic [W-1:0] mem [2**AW];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign pop_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    // Pointer update; a pop on a full FIFO frees the slot the simultaneous push reuses
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers define validity
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
    end
endmodule

module rs232_fifo_uart #(
    parameter int FREQ      = 48_000_000,
    parameter int BPS       = 115_200,
    parameter int DATA_BITS = 8,
    parameter int FIFO_AW   = 4
) (
    input  logic       clock,
    input  logic       rst,
    input  logic       sel,
    input  logic       we,
    input  logic       addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       rvalid,
    output logic       irq,
    input  logic       rxd,
    output logic       txd
);
    localparam int          DIV      = (FREQ + BPS / 2) / BPS;
    localparam logic [15:0] DIV_M1   = 16'(DIV - 1);
    localparam logic [15:0] HALF_M1  = 16'(DIV / 2 - 1);
    localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);
`ifdef RS232_PARITY_EN
    localparam bit PARITY_ON = 1'b1;
`else
    localparam bit PARITY_ON = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic rd_data, wr_data, wr_stat;
    assign rd_data = sel & ~we & ~addr;
    assign wr_data = sel &  we & ~addr;
    assign wr_stat = sel &  we &  addr;

    logic                 tx_pop, tx_empty, tx_full;
    logic [DATA_BITS-1:0] tx_head;
    logic                 rx_push, rx_empty, rx_full;
    logic [DATA_BITS-1:0] rx_head;

    state_t               tx_state, tx_state_nxt;
    logic [15:0]          tx_cnt, tx_cnt_nxt;
    logic [2:0]           tx_bit, tx_bit_nxt;
    logic [DATA_BITS-1:0] tx_sh, tx_sh_nxt;
    logic                 txd_nxt, tx_load;

    logic [1:0]           rx_sync;
    logic                 rx_s, rx_prev;
    state_t               rx_state, rx_state_nxt;
    logic [15:0]          rx_cnt, rx_cnt_nxt;
    logic [2:0]           rx_bit, rx_bit_nxt;
    logic [DATA_BITS-1:0] rx_sh, rx_sh_nxt;
    logic                 rx_pbad, rx_pbad_nxt, par_set, frame_set;

    logic                 tx_ovf, par_err, frame_err, overrun;
    logic [7:0]           status;

    rs232_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_tx_fifo (
        .clock(clock), .rst(rst), .push(wr_data), .push_dat(wdata[DATA_BITS-1:0]),
        .pop(tx_pop), .pop_dat(tx_head), .empty(tx_empty), .full(tx_full)
    );

    rs232_fifo #(.W(DATA_BITS), .AW(FIFO_AW)) u_rx_fifo (
        .clock(clock), .rst(rst), .push(rx_push), .push_dat(rx_sh),
        .pop(rd_data), .pop_dat(rx_head), .empty(rx_empty), .full(rx_full)
    );

    assign irq    = ~rx_empty;
    assign status = {1'b0, tx_ovf, par_err, frame_err, overrun,
                     tx_empty && (tx_state == S_IDLE), tx_full, ~rx_empty};
    assign tx_pop = tx_load;
    assign rx_s   = rx_sync[1];

    // Bus read port: one-cycle registered response, never stalls
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            rdata  <= 8'd0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= sel & ~we;
            if (sel & ~we) rdata <= addr ? status : 8'(rx_head);
        end
    end

    // Sticky error flags: W1C from the bus, a set in the same cycle wins over the clear
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            tx_ovf    <= 1'b0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            tx_ovf    <= (wr_data & tx_full & ~tx_pop) | (tx_ovf    & ~(wr_stat & wdata[6]));
            par_err   <= par_set                      | (par_err   & ~(wr_stat & wdata[5]));
            frame_err <= frame_set                    | (frame_err & ~(wr_stat & wdata[4]));
            overrun   <= (rx_push & rx_full & ~rd_data) | (overrun & ~(wr_stat & wdata[3]));
        end
    end

    // TX sequencing: bit timing, frame order, and fetching the next byte straight out of STOP
    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_bit_nxt   = tx_bit;
        tx_sh_nxt    = tx_sh;
        tx_load      = 1'b0;
        txd_nxt      = 1'b1;
        if (tx_state == S_IDLE) begin
            tx_load = ~tx_empty;
        end else if (tx_cnt != 16'd0) begin
            tx_cnt_nxt = tx_cnt - 16'd1;
        end else begin
            tx_cnt_nxt = DIV_M1;
            case (tx_state)
                S_START: begin
                    tx_state_nxt = S_DATA;
                    tx_bit_nxt   = 3'd0;
                end
                S_DATA: begin
                    tx_bit_nxt = tx_bit + 3'd1;
                    if (tx_bit == LAST_BIT) tx_state_nxt = PARITY_ON ? S_PARITY : S_STOP;
                end
                S_PARITY: tx_state_nxt = S_STOP;
                default: begin
                    tx_load = ~tx_empty;
                    if (tx_empty) begin
                        tx_state_nxt = S_IDLE;
                        tx_cnt_nxt   = 16'd0;
                    end
                end
            endcase
        end
        if (tx_load) begin
            tx_state_nxt = S_START;
            tx_cnt_nxt   = DIV_M1;
            tx_sh_nxt    = tx_head;
        end
        case (tx_state_nxt)
            S_START:  txd_nxt = 1'b0;
            S_DATA:   txd_nxt = tx_sh_nxt[tx_bit_nxt];
            S_PARITY: txd_nxt = ^tx_sh_nxt;
            default:  txd_nxt = 1'b1;
        endcase
    end

    // TX state register; txd is registered so the pin never glitches on state decode
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            tx_state <= S_IDLE;
            tx_cnt   <= 16'd0;
            tx_bit   <= 3'd0;
            tx_sh    <= '0;
            txd      <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_bit   <= tx_bit_nxt;
            tx_sh    <= tx_sh_nxt;
            txd      <= txd_nxt;
        end
    end

    // RX sequencing: arm on a falling edge only, so a broken stop bit must go high before re-arming
    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_bit_nxt   = rx_bit;
        rx_sh_nxt    = rx_sh;
        rx_pbad_nxt  = rx_pbad;
        rx_push      = 1'b0;
        par_set      = 1'b0;
        frame_set    = 1'b0;
        if (rx_state == S_IDLE) begin
            if (rx_prev & ~rx_s) begin
                rx_state_nxt = S_START;
                rx_cnt_nxt   = HALF_M1;
                rx_pbad_nxt  = 1'b0;
            end
        end else if (rx_cnt != 16'd0) begin
            rx_cnt_nxt = rx_cnt - 16'd1;
        end else begin
            rx_cnt_nxt = DIV_M1;
            case (rx_state)
                S_START: begin
                    if (rx_s) begin
                        rx_state_nxt = S_IDLE;
                        rx_cnt_nxt   = 16'd0;
                    end else begin
                        rx_state_nxt = S_DATA;
                        rx_bit_nxt   = 3'd0;
                    end
                end
                S_DATA: begin
                    rx_sh_nxt  = {rx_s, rx_sh[DATA_BITS-1:1]};
                    rx_bit_nxt = rx_bit + 3'd1;
                    if (rx_bit == LAST_BIT) rx_state_nxt = PARITY_ON ? S_PARITY : S_STOP;
                end
                S_PARITY: begin
                    rx_pbad_nxt  = rx_s ^ (^rx_sh);
                    rx_state_nxt = S_STOP;
                end
                default: begin
                    rx_state_nxt = S_IDLE;
                    rx_cnt_nxt   = 16'd0;
                    rx_push      = rx_s;
                    par_set      = rx_s & rx_pbad;
                    frame_set    = ~rx_s;
                end
            endcase
        end
    end

    // RX synchronizer, edge history and state register
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= 16'd0;
            rx_bit   <= 3'd0;
            rx_sh    <= '0;
            rx_pbad  <= 1'b0;
        end else begin
            rx_sync  <= {rx_sync[0], rxd};
            rx_prev  <= rx_s;
            rx_state <= rx_state_nxt;
            rx_cnt   <= rx_cnt_nxt;
            rx_bit   <= rx_bit_nxt;
            rx_sh    <= rx_sh_nxt;
            rx_pbad  <= rx_pbad_nxt;
        end
    end
endmodule
